border_link_arbiter: RTL and testbench

//  Round-robin scheduler sharing one 64-bit inter-FPGA grid link (grid_N_out) among the per-PE

---
 rtl/helios_link_pkg.sv | 28 ++
 rtl/border_link_arbiter_if.sv | 43 ++++
 rtl/rr_priority_select.sv | 51 +++++
 rtl/border_link_arbiter.sv | 106 ++++++++++
 tb/tb_border_link_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/helios_link_pkg.sv
// -----------------------------------------------------------------------------
// helios_link_pkg
// Shared definitions for the 64-bit inter-FPGA grid link.
//   DEFAULT_LINK_TAG : constant placed in beat bits [63:56]
//   TAG_LSB/IDX_LSB  : bit offsets of the tag and channel-index fields
//   PAYLOAD_W        : width of the payload field in the low part of a beat
//   link_beat_t      : packed view of one link beat {tag, idx, payload}
//   idx_width()      : index width for an N-entry selector, never below 1
// -----------------------------------------------------------------------------
package helios_link_pkg;

  localparam int              LINK_BEAT_W      = 64;
  localparam int              TAG_LSB          = 56;
  localparam int              IDX_LSB          = 48;
  localparam int              PAYLOAD_W        = 48;
  localparam logic [7:0]      DEFAULT_LINK_TAG = 8'h5A;

  typedef struct packed {
    logic [7:0]           tag;
    logic [7:0]           idx;
    logic [PAYLOAD_W-1:0] payload;
  } link_beat_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/border_link_arbiter_if.sv
// -----------------------------------------------------------------------------
// border_link_arbiter_if
// Bundles the border-channel inputs, the link output handshake and the
// controller-facing status of border_link_arbiter.
//   enable      : controller permission to issue new grants
//   in_data     : channel payloads, channel i at [i*CH_DATA_WIDTH +: CH_DATA_WIDTH]
//   in_valid    : per-channel valid
//   in_ready    : per-channel ready (one-hot or zero)
//   out_data    : link beat
//   out_valid   : link valid
//   out_ready   : link ready
//   busy        : beat held or any request pending
//   beats_sent  : count of link handshakes
//   clear_stats : synchronous clear of beats_sent
// Modports: slave = arbiter view, master = environment view.
// -----------------------------------------------------------------------------
interface border_link_arbiter_if #(
  parameter int NUM_CHANNELS  = 30,
  parameter int CH_DATA_WIDTH = 20
);

  logic                                    enable;
  logic [NUM_CHANNELS*CH_DATA_WIDTH-1:0]   in_data;
  logic [NUM_CHANNELS-1:0]                 in_valid;
  logic [NUM_CHANNELS-1:0]                 in_ready;
  logic [63:0]                             out_data;
  logic                                    out_valid;
  logic                                    out_ready;
  logic                                    busy;
  logic [31:0]                             beats_sent;
  logic                                    clear_stats;

  modport slave (
    input  enable, in_data, in_valid, out_ready, clear_stats,
    output in_ready, out_data, out_valid, busy, beats_sent
  );

  modport master (
    output enable, in_data, in_valid, out_ready, clear_stats,
    input  in_ready, out_data, out_valid, busy, beats_sent
  );

endinterface

// File: rtl/rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
// Combinational round-robin pick: the lowest requesting index at or above ptr
// wins; if none, the lowest requesting index below ptr wins.
//   req  : request vector
//   ptr  : first index with priority
//   gnt  : one-hot grant (zero when nothing requests)
//   gidx : binary index of the grant
//   any  : at least one request present
// -----------------------------------------------------------------------------
module rr_priority_select
  import helios_link_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gidx,
  output logic          any
);

  logic          hi_hit;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // NOTE: combinational logic uses blocking assignments and gives every
  // output a default first, so no path through the block infers a latch.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    any    = 1'b0;
    // Scanning downward lets the last hit overwrite earlier ones, leaving the
    // lowest index in each half.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any    = 1'b1;
        lo_idx = IW'(i);
        if (i >= int'(ptr)) begin
          hi_hit = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
    gidx = hi_hit ? hi_idx : lo_idx;
    gnt  = any ? (N'(1) << gidx) : '0;
  end

endmodule

// File: rtl/border_link_arbiter.sv
// -----------------------------------------------------------------------------
// border_link_arbiter
// Shares one 64-bit grid link among NUM_CHANNELS border output channels.
// Each grant takes one beat from one channel, tags it with LINK_TAG and the
// channel index, and places it in a registered output stage. The stage
// refills in the same cycle it is drained, giving one beat per cycle.
//   clk   : clock
//   reset : asynchronous, active-low reset
//   bus   : border_link_arbiter_if slave (channels, link, status)
// -----------------------------------------------------------------------------
module border_link_arbiter
  import helios_link_pkg::*;
#(
  parameter int         NUM_CHANNELS  = 30,
  parameter int         CH_DATA_WIDTH = 20,
  parameter int         LINK_WIDTH    = 64,
  parameter logic [7:0] LINK_TAG      = DEFAULT_LINK_TAG
) (
  input  logic                   clk,
  input  logic                   reset,
  border_link_arbiter_if.slave   bus
);

  localparam int IW = idx_width(NUM_CHANNELS);

  if (CH_DATA_WIDTH > PAYLOAD_W) begin : g_bad_data_width
    $error("CH_DATA_WIDTH must not exceed 48");
  end
  if ($clog2(NUM_CHANNELS) > 8) begin : g_bad_channel_count
    $error("channel index must fit in 8 bits");
  end
  if (LINK_WIDTH != LINK_BEAT_W) begin : g_bad_link_width
    $error("LINK_WIDTH is fixed at 64");
  end

  logic [CH_DATA_WIDTH-1:0] ch_data [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  gnt;
  logic [IW-1:0]            gidx;
  logic                     any;
  logic [IW-1:0]            ptr;
  logic                     load;
  logic                     out_valid_q;
  link_beat_t               beat_q;
  link_beat_t               beat_d;
  logic [31:0]              beats_q;
  logic                     link_fire;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_unpack
    assign ch_data[i] = bus.in_data[i*CH_DATA_WIDTH +: CH_DATA_WIDTH];
  end

  rr_priority_select #(.N(NUM_CHANNELS)) u_select (
    .req  (bus.in_valid),
    .ptr  (ptr),
    .gnt  (gnt),
    .gidx (gidx),
    .any  (any)
  );

  // Gating with reset keeps in_ready low while the output stage is held in
  // reset, so no channel can hand off a beat that would be lost.
  assign load      = reset & bus.enable & (~out_valid_q | bus.out_ready);
  assign link_fire = out_valid_q & bus.out_ready;

  always_comb begin
    beat_d.tag     = LINK_TAG;
    beat_d.idx     = 8'(gidx);
    beat_d.payload = PAYLOAD_W'(ch_data[gidx]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      beat_q      <= '0;
      ptr         <= '0;
    end else if (load) begin
      out_valid_q <= any;
      if (any) begin
        beat_q <= beat_d;
        ptr    <= (gidx == IW'(NUM_CHANNELS - 1)) ? '0 : gidx + IW'(1);
      end
    end else if (bus.out_ready) begin
      // Enable is low: the held beat drains without being replaced.
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beats_q <= '0;
    end else if (bus.clear_stats) begin
      beats_q <= '0;
    end else if (link_fire) begin
      beats_q <= beats_q + 32'd1;
    end
  end

  assign bus.in_ready   = load ? gnt : '0;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = beat_q;
  assign bus.busy       = out_valid_q | (|bus.in_valid);
  assign bus.beats_sent = beats_q;

endmodule

// File: tb/tb_border_link_arbiter.sv
// -----------------------------------------------------------------------------
// tb_border_link_arbiter
// Directed bench for border_link_arbiter with four 20-bit channels.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge unless noted.
// -----------------------------------------------------------------------------
module tb_border_link_arbiter;

  localparam int NCH = 4;
  localparam int CW  = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [CW-1:0] pay [NCH];

  border_link_arbiter_if #(.NUM_CHANNELS(NCH), .CH_DATA_WIDTH(CW)) bus ();

  border_link_arbiter #(
    .NUM_CHANNELS  (NCH),
    .CH_DATA_WIDTH (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat(input int idx);
    logic [7:0] i8;
    i8 = 8'(idx);
    return {8'h5A, i8, 28'h0, pay[idx]};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_payloads();
    for (int i = 0; i < NCH; i++) bus.in_data[i*CW +: CW] = pay[i];
  endtask

  initial begin
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};
    pay[0] = 20'hA0000;
    pay[1] = 20'hB1111;
    pay[2] = 20'hC2222;
    pay[3] = 20'h01234;

    // Reset with requests present: nothing may be granted.
    bus.enable      = 1'b1;
    bus.in_valid    = 4'hF;
    bus.in_data     = '0;
    bus.out_ready   = 1'b1;
    bus.clear_stats = 1'b0;
    set_payloads();
    #3;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_beats", 64'(bus.beats_sent), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd1);
    bus.in_valid = 4'h0;
    #9 reset = 1'b1;

    // 1: single request on ch3.
    next_cycle();
    bus.in_valid = 4'b1000;
    @(negedge clk);
    check("t1_in_ready", 64'(bus.in_ready), 64'b1000);
    check("t1_no_valid_yet", 64'(bus.out_valid), 64'd0);
    next_cycle();
    bus.in_valid = 4'b0000;
    @(negedge clk);
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_out_data", bus.out_data, 64'h5A03_0000_0000_1234);
    check("t1_in_ready_once", 64'(bus.in_ready), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t1_drained", 64'(bus.out_valid), 64'd0);
    check("t1_beats", 64'(bus.beats_sent), 64'd1);
    next_cycle();
    bus.clear_stats = 1'b1;
    next_cycle();
    bus.clear_stats = 1'b0;
    @(negedge clk);
    check("clear_beats", 64'(bus.beats_sent), 64'd0);

    // 2: all channels valid, free-flowing link.
    next_cycle();
    bus.in_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("t2_gnt%0d", k), 64'(bus.in_ready), 64'(1) << order[k]);
      if (k > 0) begin
        check($sformatf("t2_valid%0d", k), 64'(bus.out_valid), 64'd1);
        check($sformatf("t2_data%0d", k), bus.out_data, beat(order[k-1]));
      end
      next_cycle();
    end
    bus.in_valid = 4'h0;
    @(negedge clk);
    check("t2_last_data", bus.out_data, beat(1));
    check("t2_beats5", 64'(bus.beats_sent), 64'd5);
    next_cycle();
    @(negedge clk);
    check("t2_beats6", 64'(bus.beats_sent), 64'd6);
    check("t2_idle", 64'(bus.out_valid), 64'd0);

    // 3: backpressure for five cycles, then refill in the draining cycle.
    next_cycle();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'hF;
    @(negedge clk);
    check("t3_gnt2", 64'(bus.in_ready), 64'b0100);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t3_hold_valid%0d", k), 64'(bus.out_valid), 64'd1);
      check($sformatf("t3_hold_data%0d", k), bus.out_data, beat(2));
      check($sformatf("t3_hold_rdy%0d", k), 64'(bus.in_ready), 64'd0);
      next_cycle();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t3_refill_gnt", 64'(bus.in_ready), 64'b1000);
    next_cycle();
    bus.in_valid = 4'h0;
    @(negedge clk);
    check("t3_refill_data", bus.out_data, beat(3));
    next_cycle();
    @(negedge clk);
    check("t3_idle", 64'(bus.out_valid), 64'd0);

    // 4: wrap-around behaviour.
    next_cycle();
    bus.in_valid = 4'b1010;
    @(negedge clk);
    check("t4_ptr0_gnt1", 64'(bus.in_ready), 64'b0010);
    next_cycle();
    @(negedge clk);
    check("t4_then_gnt3", 64'(bus.in_ready), 64'b1000);
    check("t4_data1", bus.out_data, beat(1));
    next_cycle();
    bus.in_valid = 4'b0100;
    @(negedge clk);
    check("t4_gnt2", 64'(bus.in_ready), 64'b0100);
    check("t4_data3", bus.out_data, beat(3));
    next_cycle();
    bus.in_valid = 4'b1001;
    @(negedge clk);
    check("t4_ptr3_gnt3", 64'(bus.in_ready), 64'b1000);
    next_cycle();
    @(negedge clk);
    check("t4_wrap_gnt0", 64'(bus.in_ready), 64'b0001);
    next_cycle();
    bus.in_valid = 4'h0;
    @(negedge clk);
    check("t4_data0", bus.out_data, beat(0));
    next_cycle();

    // 5: enable dropped mid-stream.
    next_cycle();
    bus.in_valid = 4'hF;
    @(negedge clk);
    check("t5_gnt1", 64'(bus.in_ready), 64'b0010);
    next_cycle();
    bus.enable = 1'b0;
    @(negedge clk);
    check("t5_no_gnt", 64'(bus.in_ready), 64'd0);
    check("t5_held_data", bus.out_data, beat(1));
    check("t5_held_valid", 64'(bus.out_valid), 64'd1);
    next_cycle();
    @(negedge clk);
    check("t5_drained", 64'(bus.out_valid), 64'd0);
    check("t5_busy", 64'(bus.busy), 64'd1);
    check("t5_no_gnt2", 64'(bus.in_ready), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t5_still_idle", 64'(bus.out_valid), 64'd0);
    next_cycle();
    bus.enable = 1'b1;
    @(negedge clk);
    check("t5_resume_gnt2", 64'(bus.in_ready), 64'b0100);
    next_cycle();
    bus.in_valid = 4'h0;
    @(negedge clk);
    check("t5_resume_data", bus.out_data, beat(2));
    next_cycle();
    @(negedge clk);
    check("t5_not_busy", 64'(bus.busy), 64'd0);

    // 6: asynchronous reset mid-stream, then clear_stats against a handshake.
    next_cycle();
    bus.in_valid = 4'hF;
    @(negedge clk);
    check("t6_gnt3", 64'(bus.in_ready), 64'b1000);
    next_cycle();
    @(negedge clk);
    check("t6_pre_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_beats", 64'(bus.beats_sent), 64'd0);
    check("t6_rst_data", bus.out_data, 64'd0);
    check("t6_rst_rdy", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 4'b1100;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_first_gnt", 64'(bus.in_ready), 64'b0100);
    next_cycle();
    @(negedge clk);
    check("t6_data2", bus.out_data, beat(2));
    check("t6_beats0", 64'(bus.beats_sent), 64'd0);
    check("t6_next_gnt", 64'(bus.in_ready), 64'b1000);
    bus.clear_stats = 1'b1;
    next_cycle();
    bus.clear_stats = 1'b0;
    bus.in_valid    = 4'h0;
    @(negedge clk);
    check("t6_clear_wins", 64'(bus.beats_sent), 64'd0);
    check("t6_data3", bus.out_data, beat(3));
    next_cycle();
    @(negedge clk);
    check("t6_count_after", 64'(bus.beats_sent), 64'd1);
    check("t6_idle", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
